// File: rtl/wave_meter.sv
// wave_meter -- measures phase, high time, low time and period of an
// asynchronous periodic input, in clk cycles.
//
// Optional feature macro: WAVE_METER_GLITCH_FILTER_EN
//   Defined   : a level must be seen on two consecutive synchronized samples
//               before it is accepted; single-cycle glitches are dropped and
//               all latencies grow by one cycle.
//   Undefined : the synchronizer output feeds edge detection directly.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   enable       arms measurement while high; low returns to IDLE
//   wave_in      asynchronous waveform under measurement
//   phase_cnt    cycles from arming to the first detected rise
//   ton_cnt      high time of the last complete cycle
//   toff_cnt     low time of the last complete cycle
//   period_cnt   ton_cnt + toff_cnt (one bit wider, never overflows)
//   meas_valid   one-cycle pulse when ton/toff/period update
//   phase_valid  one-cycle pulse when phase_cnt updates
//   sat          sticky: some counter saturated since arming
//   busy         high in any state other than IDLE
module wave_meter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             wave_in,
  output logic [CNT_W-1:0] phase_cnt,
  output logic [CNT_W-1:0] ton_cnt,
  output logic [CNT_W-1:0] toff_cnt,
  output logic [CNT_W:0]   period_cnt,
  output logic             meas_valid,
  output logic             phase_valid,
  output logic             sat,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_NEAR = CNT_MAX - 1'b1;

  state_t           r_state;
  logic             r_s1, r_s2, r_s3;
  logic             w_lvl, w_rise, w_fall;
  logic [CNT_W-1:0] r_cnt, w_cnt_inc, r_ton;
  logic             w_sat_hit;
  logic [CNT_W-1:0] r_phase, r_ton_out, r_toff;
  logic [CNT_W:0]   r_period;
  logic             r_meas_valid, r_phase_valid, r_sat;

`ifdef WAVE_METER_GLITCH_FILTER_EN
  logic r_s2d;

  always_ff @(posedge clk) begin
    if (!rst_n) r_s2d <= 1'b0;
    else        r_s2d <= r_s2;
  end

  // Accept the synchronized level only when two consecutive samples agree;
  // otherwise hold the last accepted level so no edge is seen.
  assign w_lvl = (r_s2 == r_s2d) ? r_s2 : r_s3;
`else
  assign w_lvl = r_s2;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= wave_in;
      r_s2 <= r_s1;
      r_s3 <= w_lvl;
    end
  end

  assign w_rise = w_lvl & ~r_s3;
  assign w_fall = ~w_lvl & r_s3;

  always_comb begin
    w_cnt_inc = r_cnt;
    if (r_cnt != CNT_MAX) w_cnt_inc = r_cnt + 1'b1;
  end

  // The increment that lands on CNT_MAX is the one that raises sat.
  assign w_sat_hit = (r_cnt == CNT_NEAR);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_ton         <= '0;
      r_phase       <= '0;
      r_ton_out     <= '0;
      r_toff        <= '0;
      r_period      <= '0;
      r_meas_valid  <= 1'b0;
      r_phase_valid <= 1'b0;
      r_sat         <= 1'b0;
    end else begin
      r_meas_valid  <= 1'b0;
      r_phase_valid <= 1'b0;
      if (!enable) begin
        // Disable wins over any edge detected in the same cycle.
        r_state <= IDLE;
        r_cnt   <= '0;
        r_sat   <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_state <= ARM;
            r_cnt   <= '0;
          end
          ARM: begin
            if (w_rise) begin
              r_phase       <= r_cnt;
              r_phase_valid <= 1'b1;
              r_cnt         <= {{(CNT_W-1){1'b0}}, 1'b1};
              r_state       <= HIGH;
            end else begin
              r_cnt <= w_cnt_inc;
              if (w_sat_hit) r_sat <= 1'b1;
            end
          end
          HIGH: begin
            if (w_fall) begin
              r_ton   <= r_cnt;
              r_cnt   <= {{(CNT_W-1){1'b0}}, 1'b1};
              r_state <= LOW;
            end else begin
              r_cnt <= w_cnt_inc;
              if (w_sat_hit) r_sat <= 1'b1;
            end
          end
          LOW: begin
            if (w_rise) begin
              r_ton_out    <= r_ton;
              r_toff       <= r_cnt;
              r_period     <= {1'b0, r_ton} + {1'b0, r_cnt};
              r_meas_valid <= 1'b1;
              r_cnt        <= {{(CNT_W-1){1'b0}}, 1'b1};
              r_state      <= HIGH;
            end else begin
              r_cnt <= w_cnt_inc;
              if (w_sat_hit) r_sat <= 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign phase_cnt   = r_phase;
  assign ton_cnt     = r_ton_out;
  assign toff_cnt    = r_toff;
  assign period_cnt  = r_period;
  assign meas_valid  = r_meas_valid;
  assign phase_valid = r_phase_valid;
  assign sat         = r_sat;
  assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_wave_meter.sv
// Testbench for wave_meter (CNT_W=4). Expected pulses are queued as each
// scenario starts; a negedge monitor pops and compares on every valid pulse.
module tb_wave_meter;

  localparam int unsigned CW = 4;
`ifdef WAVE_METER_GLITCH_FILTER_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          wave_in = 1'b0;
  logic [CW-1:0] phase_cnt, ton_cnt, toff_cnt;
  logic [CW:0]   period_cnt;
  logic          meas_valid, phase_valid, sat, busy;

  wave_meter #(.CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .wave_in    (wave_in),
    .phase_cnt  (phase_cnt),
    .ton_cnt    (ton_cnt),
    .toff_cnt   (toff_cnt),
    .period_cnt (period_cnt),
    .meas_valid (meas_valid),
    .phase_valid(phase_valid),
    .sat        (sat),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit    is_meas;
    int    a;
    int    b;
    int    c;
    bit    sat;
    string name;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic push_phase(input string name, input int ph);
    exp_t e;
    e.is_meas = 1'b0; e.a = ph; e.b = 0; e.c = 0; e.sat = 1'b0; e.name = name;
    q.push_back(e);
  endtask

  task automatic push_meas(input string name, input int ton, input int toff,
                           input int per, input bit s);
    exp_t e;
    e.is_meas = 1'b1; e.a = ton; e.b = toff; e.c = per; e.sat = s; e.name = name;
    q.push_back(e);
  endtask

  // Monitor: every valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (phase_valid || meas_valid) begin
      if (q.size() == 0) begin
        check("unexpected_pulse", q.size(), 1);
      end else begin
        exp_t e;
        e = q.pop_front();
        check({e.name, "_kind"}, int'(meas_valid), int'(e.is_meas));
        if (e.is_meas) begin
          check({e.name, "_ton"},    int'(ton_cnt),    e.a);
          check({e.name, "_toff"},   int'(toff_cnt),   e.b);
          check({e.name, "_period"}, int'(period_cnt), e.c);
        end else begin
          check({e.name, "_phase"},  int'(phase_cnt),  e.a);
        end
        check({e.name, "_sat"}, int'(sat), int'(e.sat));
      end
    end
  end

  // Each call drives n consecutive slots, 3 ns after successive rising edges.
  task automatic lvl(input bit v, input int n);
    repeat (n) begin
      @(posedge clk); #3;
      wave_in = v;
    end
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while (q.size() != 0 && k < 100) begin
      @(negedge clk); #1;
      k++;
    end
    check({name, "_drain"}, q.size(), 0);
  endtask

  // Drop enable with wave low and verify the idle/retained state.
  task automatic disable_check(input string name, input int ph, input int ton,
                               input int toff, input int per);
    @(posedge clk); #3;
    enable  = 1'b0;
    wave_in = 1'b0;
    @(posedge clk); #1;
    check({name, "_busy_off"}, int'(busy), 0);
    check({name, "_sat_off"},  int'(sat), 0);
    check({name, "_phase_kept"}, int'(phase_cnt), ph);
    check({name, "_ton_kept"},   int'(ton_cnt), ton);
    check({name, "_toff_kept"},  int'(toff_cnt), toff);
    check({name, "_per_kept"},   int'(period_cnt), per);
    repeat (5) @(posedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached with %0d expectations pending", q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_phase",  int'(phase_cnt), 0);
    check("rst_ton",    int'(ton_cnt), 0);
    check("rst_toff",   int'(toff_cnt), 0);
    check("rst_period", int'(period_cnt), 0);
    check("rst_mvalid", int'(meas_valid), 0);
    check("rst_pvalid", int'(phase_valid), 0);
    check("rst_sat",    int'(sat), 0);
    check("rst_busy",   int'(busy), 0);
    #2 rst_n = 1'b1;
    repeat (4) @(posedge clk);

    // T1: phase 7 slots, then high 5 / low 3 repeating.
    @(negedge clk); enable = 1'b1;
    push_phase("t1_phase", 7 + LAT);
    push_meas("t1_m0", 5, 3, 8, 1'b0);
    push_meas("t1_m1", 5, 3, 8, 1'b0);
    push_meas("t1_m2", 5, 3, 8, 1'b0);
    lvl(1'b0, 7);
    repeat (3) begin
      lvl(1'b1, 5);
      lvl(1'b0, 3);
    end
    lvl(1'b1, 4);
    check("t1_busy", int'(busy), 1);
    wait_drain("t1");
    disable_check("t1", 7 + LAT, 5, 3, 8);

    // T2: wave already high when armed; fall then rise starts the phase.
    lvl(1'b1, 5);
    @(negedge clk); enable = 1'b1;
    push_phase("t2_phase", 7 + LAT);
    push_meas("t2_m0", 5, 3, 8, 1'b0);
    lvl(1'b1, 3);
    lvl(1'b0, 4);
    lvl(1'b1, 5);
    lvl(1'b0, 3);
    lvl(1'b1, 4);
    wait_drain("t2");
    disable_check("t2", 7 + LAT, 5, 3, 8);

    // T3: high for 20 cycles saturates the 4-bit counter.
    @(negedge clk); enable = 1'b1;
    push_phase("t3_phase", 2 + LAT);
    push_meas("t3_m0", 15, 3, 18, 1'b1);
    lvl(1'b0, 2);
    lvl(1'b1, 20);
    lvl(1'b0, 3);
    lvl(1'b1, 4);
    wait_drain("t3");
    check("t3_sat_held", int'(sat), 1);
    disable_check("t3", 2 + LAT, 15, 3, 18);

    // T4: reset while in HIGH, then a fresh measurement from ARM.
    @(negedge clk); enable = 1'b1;
    push_phase("t4_phase_a", 2 + LAT);
    push_phase("t4_phase_b", 4 + LAT);
    push_meas("t4_m0", 3, 2, 5, 1'b0);
    lvl(1'b0, 2);
    lvl(1'b1, 4);
    @(posedge clk); #3;
    wave_in = 1'b0;
    rst_n   = 1'b0;
    @(posedge clk); #1;
    check("t4_rst_phase",  int'(phase_cnt), 0);
    check("t4_rst_ton",    int'(ton_cnt), 0);
    check("t4_rst_toff",   int'(toff_cnt), 0);
    check("t4_rst_period", int'(period_cnt), 0);
    check("t4_rst_sat",    int'(sat), 0);
    check("t4_rst_busy",   int'(busy), 0);
    #2 rst_n = 1'b1;
    lvl(1'b0, 4);
    lvl(1'b1, 3);
    lvl(1'b0, 2);
    lvl(1'b1, 4);
    wait_drain("t4");
    disable_check("t4", 4 + LAT, 3, 2, 5);

    // T5: enable drops on the very edge that would register a rise.
    @(negedge clk); enable = 1'b1;
    push_phase("t5_phase", 2 + LAT);
    push_meas("t5_m0", 4, 2, 6, 1'b0);
    lvl(1'b0, 2);
    lvl(1'b1, 4);
    lvl(1'b0, 2);
    lvl(1'b1, 3);
    lvl(1'b0, 3);
    lvl(1'b1, 1);
    lvl(1'b1, LAT);
    enable = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("t5_busy_off", int'(busy), 0);
    check("t5_ton_kept", int'(ton_cnt), 4);
    check("t5_toff_kept", int'(toff_cnt), 2);
    check("t5_per_kept", int'(period_cnt), 6);
    wait_drain("t5");
    wave_in = 1'b0;
    repeat (6) @(posedge clk);

    // T6: one-cycle high glitch inside a low phase.
    @(negedge clk); enable = 1'b1;
    push_phase("t6_phase", 2 + LAT);
`ifdef WAVE_METER_GLITCH_FILTER_EN
    push_meas("t6_m0", 4, 6, 10, 1'b0);
`else
    push_meas("t6_m0", 4, 2, 6, 1'b0);
    push_meas("t6_glitch", 1, 3, 4, 1'b0);
`endif
    push_meas("t6_m2", 4, 3, 7, 1'b0);
    lvl(1'b0, 2);
    lvl(1'b1, 4);
    lvl(1'b0, 2);
    lvl(1'b1, 1);
    lvl(1'b0, 3);
    lvl(1'b1, 4);
    lvl(1'b0, 3);
    lvl(1'b1, 4);
    wait_drain("t6");
    disable_check("t6", 2 + LAT, 4, 3, 7);

    check("final_queue", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/wave_meter.md
# wave_meter

Synthesizable waveform measurement stage that sits directly downstream of the bench clock/pulse generators. It samples an asynchronous periodic input against the system clock and reports, in clk cycles, the initial phase delay, high time, low time and period of every complete cycle. It lets a bench or on-chip self-check confirm a generated waveform's phase, on-time and off-time settings cycle-exactly.

## Interface
Parameters:
- CNT_W, 16, width of the phase, high-time and low-time counters and outputs.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- enable  input  1  arms measurement while high; low returns the block to IDLE.
- wave_in  input  1  asynchronous waveform under measurement.
- phase_cnt  output  CNT_W  cycles from arming to the first detected rise.
- ton_cnt  output  CNT_W  high time of the last complete cycle.
- toff_cnt  output  CNT_W  low time of the last complete cycle.
- period_cnt  output  CNT_W+1  ton_cnt + toff_cnt; never overflows.
- meas_valid  output  1  one-cycle pulse when ton/toff/period update.
- phase_valid  output  1  one-cycle pulse when phase_cnt updates.
- sat  output  1  sticky flag: some counter saturated.
- busy  output  1  high in any state other than IDLE.

## Operation
- Input path: wave_in goes through a 2-FF synchronizer (s1, s2), then an edge register s3.
  - rise = s2 & ~s3.
  - fall = ~s2 & s3.
- Internal counter cnt (CNT_W bits) increments every cycle and saturates at 2^CNT_W-1.
  - Reaching saturation sets sat.
  - On a detected edge, cnt reloads to 1, so a level held for N samples measures N.
- FSM states and transitions:
  - IDLE: cnt=0. On enable=1, go to ARM; cnt restarts from 0.
  - ARM: counts phase. On rise, capture phase_cnt=cnt, pulse phase_valid, go to HIGH. A wave already high at arming is not an edge; the block waits for its fall and then a rise.
  - HIGH: on fall, latch ton internally from cnt, go to LOW.
  - LOW: on rise, register ton_cnt, toff_cnt=cnt and period_cnt=ton+toff; pulse meas_valid; go to HIGH.
- The first meas_valid requires one full high-then-low cycle after the first rise.
- enable=0 in any state: next state IDLE, sat cleared, no valid pulses. Result outputs keep their last values.
- rst_n=0: state IDLE. All outputs 0: phase_cnt, ton_cnt, toff_cnt, period_cnt, meas_valid, phase_valid, sat, busy. Synchronizer flops also 0.
- Reset or disable mid-measurement discards the partial cycle.
- Saturated counts are reported as 2^CNT_W-1; period_cnt is still their exact sum.

## Timing
- wave_in change sampled at edge k:
  - s2 valid after edge k+1.
  - Edge detected combinationally in cycle k+1..k+2.
  - State, outputs and valid pulses registered at edge k+2.
- Latency from wave_in edge to meas_valid/phase_valid: 2 cycles (3 with the filter).
- Reported phase_cnt = true phase in cycles + synchronizer latency (2, or 3 with the filter).
  - ton and toff are latency-free, because both edges carry equal latency.
- meas_valid and phase_valid are single-cycle pulses, never back-to-back from the same edge.
- Minimum measurable level is 1 cycle (2 with the filter).
- Simultaneous enable=0 and a detected edge: disable wins; no pulse is issued.

## Configuration
- WAVE_METER_GLITCH_FILTER_EN defined:
  - Adds a stability stage after s2: a level is accepted only after 2 consecutive equal samples.
  - Single-cycle glitches are ignored.
  - All latencies grow by 1 cycle.
- Undefined: s2 feeds edge detection directly, and any 1-cycle level is measured.

## Test plan
- clk 10 ns; wave_in edges 3 ns after clk edges; phase 70 ns, high 50 ns, low 30 ns, enable at t=0 → phase_cnt=9 with phase_valid. First meas_valid gives ton_cnt=5, toff_cnt=3, period_cnt=8, repeating every 8 cycles.
- wave_in held high when enable rises, falls at 40 ns, rises at 80 ns → no phase_valid before the 80 ns rise; phase_cnt counts from arming.
- CNT_W=4, high for 20 cycles, low 3 → ton_cnt=15, sat=1, toff_cnt=3, period_cnt=18; sat clears when enable drops.
- rst_n=0 for one cycle mid-HIGH → all outputs 0 next cycle; busy=0; the next measurement restarts from ARM.
- enable=0 one cycle before a rise → no meas_valid; previous ton/toff values retained.
- 1-cycle glitch in the low phase:
  - With the macro: ignored, values unchanged.
  - Without the macro: reports ton_cnt=1.
